vertex_fetch: RTL

//  Upstream feeder for the transformation stage. On start_in, walks the vertex ROM and reads

---
 rtl/fpga3d_pkg.sv | 15 +
 rtl/vertex_fetch_if.sv | 10 +
 rtl/vertex_fetch.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fpga3d_pkg.sv
// Shared types and constants for the vertex front end.
package fpga3d_pkg;

  localparam logic [31:0] FP_ONE              = 32'h3f800000;
  localparam int          WORDS_PER_VERT_FULL = 4;
  localparam int          WORDS_PER_VERT_XYZ  = 3;

  typedef enum logic [1:0] {
    VF_IDLE,
    VF_ISSUE,
    VF_COLLECT,
    VF_PRESENT
  } vf_state_t;

endpackage

// File: rtl/vertex_fetch_if.sv
// Vertex output handshake: assembled position words plus valid/ready and last-vertex flag.
interface vertex_fetch_if;
  logic [3:0][31:0] pos_out;
  logic             valid_out;
  logic             obj_done_out;
  logic             ready_in;

  modport master (output pos_out, valid_out, obj_done_out, input ready_in);
  modport slave  (input pos_out, valid_out, obj_done_out, output ready_in);
endinterface

// File: rtl/vertex_fetch.sv
// Walks the vertex ROM, assembles float32 words into vertices and hands them downstream.
// Build option VERTEX_FETCH_W_FORCE_EN: read x,y,z only (stride 3) and force w to 1.0.
module vertex_fetch
  import fpga3d_pkg::*;
#(
  parameter int NUM_VERTS   = 36,
  parameter int ROM_LATENCY = 2,
  parameter int ADDR_W      = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [31:0]       rom_data_in,
  output logic [ADDR_W-1:0] rom_addr_out,
  output logic              busy_out,
  vertex_fetch_if.master    vf
);

`ifdef VERTEX_FETCH_W_FORCE_EN
  localparam int WPV = WORDS_PER_VERT_XYZ;
`else
  localparam int WPV = WORDS_PER_VERT_FULL;
`endif
  localparam int             VIW      = (NUM_VERTS > 1) ? $clog2(NUM_VERTS) : 1;
  localparam logic [VIW-1:0] LAST_IDX = VIW'(NUM_VERTS - 1);

  vf_state_t               state_reg;
  logic [VIW-1:0]          vert_idx_reg;
  logic [2:0]              iss_cnt_reg;
  logic [1:0]              cap_cnt_reg;
  logic                    addr_valid_reg;
  logic [ROM_LATENCY-1:0]  tag_reg;
  logic [3:0][31:0]        pos_reg;
  logic                    valid_reg;
  logic                    done_reg;
  logic                    busy_reg;
  logic [ADDR_W-1:0]       addr_reg;

  // Tag pipeline: bit ROM_LATENCY-1 is high in the cycle the requested word is on rom_data_in.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      tag_reg <= '0;
    end else begin
      tag_reg[0] <= addr_valid_reg;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_reg[i] <= tag_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_reg      <= VF_IDLE;
      vert_idx_reg   <= '0;
      iss_cnt_reg    <= '0;
      cap_cnt_reg    <= '0;
      addr_valid_reg <= 1'b0;
      pos_reg        <= '0;
      valid_reg      <= 1'b0;
      done_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      addr_reg       <= '0;
    end else begin
      case (state_reg)
        VF_IDLE: begin
          if (start_in) begin
            state_reg      <= VF_ISSUE;
            busy_reg       <= 1'b1;
            vert_idx_reg   <= '0;
            addr_reg       <= '0;
            addr_valid_reg <= 1'b1;
            iss_cnt_reg    <= 3'd1;
            cap_cnt_reg    <= '0;
          end
        end
        VF_ISSUE: begin
          if (iss_cnt_reg == 3'(WPV)) begin
            addr_valid_reg <= 1'b0;
            state_reg      <= VF_COLLECT;
          end else begin
            addr_reg    <= addr_reg + 1'b1;
            iss_cnt_reg <= iss_cnt_reg + 3'd1;
          end
        end
        VF_COLLECT: ;
        VF_PRESENT: begin
          if (vf.ready_in) begin
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            if (done_reg) begin
              state_reg <= VF_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              // Next vertex base directly follows the last word of this one.
              vert_idx_reg   <= vert_idx_reg + 1'b1;
              addr_reg       <= addr_reg + 1'b1;
              addr_valid_reg <= 1'b1;
              iss_cnt_reg    <= 3'd1;
              state_reg      <= VF_ISSUE;
            end
          end
        end
        default: state_reg <= VF_IDLE;
      endcase

      // Words return in issue order, the first ones already while still issuing.
      if (tag_reg[ROM_LATENCY-1]) begin
        pos_reg[cap_cnt_reg] <= rom_data_in;
        if (cap_cnt_reg == 2'(WPV - 1)) begin
          cap_cnt_reg <= '0;
          state_reg   <= VF_PRESENT;
          valid_reg   <= 1'b1;
          done_reg    <= (vert_idx_reg == LAST_IDX);
`ifdef VERTEX_FETCH_W_FORCE_EN
          pos_reg[3]  <= FP_ONE;
`endif
        end else begin
          cap_cnt_reg <= cap_cnt_reg + 2'd1;
        end
      end
    end
  end

  assign rom_addr_out    = addr_reg;
  assign busy_out        = busy_reg;
  assign vf.valid_out    = valid_reg;
  assign vf.obj_done_out = done_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_pos
    assign vf.pos_out[gi] = pos_reg[gi];
  end

endmodule
